ds_block_scaler: RTL and testbench

Parametrised streaming image downscaler that reduces a raster-order frame by FACTOR×FACTOR, where FACTOR = 2^LOG2_FACTOR, on all colour channels at once. It supports two modes: decimation (pick the top-left pixel of each block) and box-average (mean of each block). It sits between the pixel source (frame buffer read-out after RGB unpack) and the RGB repack / output writer. It replaces the fixed per-channel 8×8 select downsampler with one instance covering every channel.

---
 rtl/ds_block_scaler_if.sv | 25 ++
 rtl/ds_block_scaler.sv | 134 +++++++++++++
 tb/tb_ds_block_scaler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ds_block_scaler_if.sv
// Pixel stream bundle between the frame source, the block scaler and the repack stage.
// Valid-only handshake: a beat transfers whenever *_valid is high on a rising clk; there is no ready and the sink takes every beat.
interface ds_block_scaler_if #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3
) ();
    logic                         mode;
    logic                         frame_start;
    logic                         in_valid;
    logic [CHANNELS*DATA_W-1:0]   in_data;
    logic                         out_valid;
    logic [CHANNELS*DATA_W-1:0]   out_data;
    logic                         out_eol;
    logic                         out_eof;

    modport master (
        output mode, frame_start, in_valid, in_data,
        input  out_valid, out_data, out_eol, out_eof
    );

    modport slave (
        input  mode, frame_start, in_valid, in_data,
        output out_valid, out_data, out_eol, out_eof
    );
endinterface

// File: rtl/ds_block_scaler.sv
// Streaming FACTOR x FACTOR downscaler over all channels: top-left select or box average,
// with registered outputs one clk after the triggering input beat.
module ds_block_scaler #(
    parameter int DATA_W      = 8,
    parameter int CHANNELS    = 3,
    parameter int IMG_W       = 256,
    parameter int IMG_H       = 256,
    parameter int LOG2_FACTOR = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    ds_block_scaler_if.slave bus
);
    localparam int FACTOR = 1 << LOG2_FACTOR;
    localparam int OUT_W  = IMG_W / FACTOR;
    localparam int OUT_H  = IMG_H / FACTOR;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int BW     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int HW     = DATA_W + LOG2_FACTOR;
    localparam int LW     = DATA_W + 2 * LOG2_FACTOR;
    localparam int PW     = CHANNELS * DATA_W;
    localparam logic [CW-1:0] COL_MASK = CW'(FACTOR - 1);
    localparam logic [RW-1:0] ROW_MASK = RW'(FACTOR - 1);

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic          active_mode_q, active_mode_d, mode_eff;
    logic [HW-1:0] hsum_q [CHANNELS];
    logic [HW-1:0] hsum_d [CHANNELS];
    logic [LW-1:0] lbuf_q [CHANNELS][OUT_W];
    logic [LW-1:0] tot    [CHANNELS];
    logic [PW-1:0] avg_pix;
    logic [BW-1:0] blk;
    logic          at_origin, col_first, col_last, row_first, row_last;
    logic          line_end, frame_end_row, fire, lbuf_we;
    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_data_q, out_data_d;
    logic          out_eol_q, out_eol_d;
    logic          out_eof_q, out_eof_d;

    // frame_start relocates the current beat to (0,0), so every decode below uses the effective position.
    always_comb begin
        col_cur       = bus.frame_start ? '0 : col_q;
        row_cur       = bus.frame_start ? '0 : row_q;
        at_origin     = (col_cur == '0) && (row_cur == '0);
        mode_eff      = at_origin ? bus.mode : active_mode_q;
        col_first     = (col_cur & COL_MASK) == '0;
        col_last      = (col_cur & COL_MASK) == COL_MASK;
        row_first     = (row_cur & ROW_MASK) == '0;
        row_last      = (row_cur & ROW_MASK) == ROW_MASK;
        blk           = BW'(col_cur >> LOG2_FACTOR);
        line_end      = blk == BW'(OUT_W - 1);
        frame_end_row = (row_cur >> LOG2_FACTOR) == RW'(OUT_H - 1);
        fire          = bus.in_valid && (mode_eff ? (col_last && row_last) : (col_first && row_first));
        lbuf_we       = bus.in_valid && col_last;
    end

    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        active_mode_d = active_mode_q;
        if (bus.frame_start) begin
            col_d = '0;
            row_d = '0;
        end
        if (bus.in_valid) begin
            if (at_origin)
                active_mode_d = bus.mode;
            if (col_cur == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_cur == RW'(IMG_H - 1)) ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
                row_d = row_cur;
            end
        end
    end

    // Loading at the first column/row of a block makes any aborted partial sums irrelevant.
    always_comb begin
        avg_pix = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            hsum_d[ch] = (col_first ? '0 : hsum_q[ch]) + HW'(bus.in_data[ch*DATA_W +: DATA_W]);
            tot[ch]    = (row_first ? '0 : lbuf_q[ch][blk]) + LW'(hsum_d[ch]);
            avg_pix[ch*DATA_W +: DATA_W] = DATA_W'(tot[ch] >> (2 * LOG2_FACTOR));
        end
    end

    always_comb begin
        out_valid_d = fire;
        out_data_d  = out_data_q;
        if (fire)
            out_data_d = mode_eff ? avg_pix : bus.in_data;
        out_eol_d   = fire && line_end;
        out_eof_d   = fire && line_end && frame_end_row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q         <= '0;
            row_q         <= '0;
            active_mode_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_eol_q     <= 1'b0;
            out_eof_q     <= 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                hsum_q[ch] <= '0;
                for (int b = 0; b < OUT_W; b++)
                    lbuf_q[ch][b] <= '0;
            end
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            active_mode_q <= active_mode_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_eol_q     <= out_eol_d;
            out_eof_q     <= out_eof_d;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (bus.in_valid)
                    hsum_q[ch] <= hsum_d[ch];
                if (lbuf_we)
                    lbuf_q[ch][blk] <= tot[ch];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.out_eof   = out_eof_q;
endmodule

// File: tb/tb_ds_block_scaler.sv
// Directed bench for ds_block_scaler on a 16x16 frame with 4x4 blocks; expected pixels come from
// hand-computed ramp tables and every output is matched in order, value, flags and exact arrival cycle.
module tb_ds_block_scaler;
    localparam int DW = 8;
    localparam int CH = 3;
    localparam int IW = 16;
    localparam int IH = 16;
    localparam int L2 = 2;
    localparam int EW = 58;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    ds_block_scaler_if #(.DATA_W(DW), .CHANNELS(CH)) bus ();

    ds_block_scaler #(
        .DATA_W(DW), .CHANNELS(CH), .IMG_W(IW), .IMG_H(IH), .LOG2_FACTOR(L2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    // entry = {due cycle[57:26], eof[25], eol[24], data[23:0]}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    logic [7:0] sel_ch0 [16] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h40, 8'h44, 8'h48, 8'h4C,
                                 8'h80, 8'h84, 8'h88, 8'h8C, 8'hC0, 8'hC4, 8'hC8, 8'hCC};
    logic [7:0] avg_ch0 [16] = '{8'h19, 8'h1D, 8'h21, 8'h25, 8'h59, 8'h5D, 8'h61, 8'h65,
                                 8'h99, 8'h9D, 8'hA1, 8'hA5, 8'hD9, 8'hDD, 8'hE1, 8'hE5};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] ramp(input int r, input int c);
        logic [7:0] v;
        v = 8'(16 * r + c);
        return {8'h80, 8'hFF - v, v};
    endfunction

    function automatic logic [23:0] expect_pix(input bit m, input bit ff, input int k);
        if (ff) return 24'hFFFFFF;
        if (m)  return {8'h80, 8'hFE - avg_ch0[k], avg_ch0[k]};
        return {8'h80, 8'hFF - sel_ch0[k], sel_ch0[k]};
    endfunction

    // driver tasks
    task automatic idle_beat();
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic run_frame(input bit m, input bit fs_first, input int npix,
                             input int gap_pct, input int toggle_at, input bit ff);
        for (int p = 0; p < npix; p++) begin
            int r, c, k;
            bit trig;
            r = p / IW;
            c = p % IW;
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
                idle_beat();
            @(posedge clk);
            #1;
            bus.in_valid    = 1'b1;
            bus.frame_start = fs_first && (p == 0);
            if (p == 0)         bus.mode = m;
            if (p == toggle_at) bus.mode = ~m;
            bus.in_data = ff ? 24'hFFFFFF : ramp(r, c);
            trig = m ? ((r % 4 == 3) && (c % 4 == 3)) : ((r % 4 == 0) && (c % 4 == 0));
            if (trig) begin
                k = (r / 4) * 4 + c / 4;
                exp_q.push_back({32'(cycle + 1), 1'(k == 15), 1'(c / 4 == 3), expect_pix(m, ff, k)});
            end
        end
    endtask

    task automatic drain(input string tag);
        repeat (4) idle_beat();
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && int'(exp_q[0][57:26]) < cycle) begin
                check("missed_output", 64'(cycle), 64'(exp_q[0][57:26]));
                void'(exp_q.pop_front());
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stray_output", 64'(bus.out_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", 64'(bus.out_data), 64'(mon_e[23:0]));
                    check("out_eol",  64'(bus.out_eol),  64'(mon_e[24]));
                    check("out_eof",  64'(bus.out_eof),  64'(mon_e[25]));
                    check("latency",  64'(cycle),        64'(mon_e[57:26]));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b1;
        bus.mode        = 1'b0;
        bus.frame_start = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_out_eol",   64'(bus.out_eol),   64'd0);
        check("rst_out_eof",   64'(bus.out_eof),   64'd0);
        rst_n = 1'b1;

        // select and average on the ramp, continuous input
        run_frame(1'b0, 1'b0, 256, 0, -1, 1'b0);
        drain("drain_select_ramp");
        run_frame(1'b1, 1'b0, 256, 0, -1, 1'b0);
        drain("drain_average_ramp");

        // saturated input with random gaps
        run_frame(1'b1, 1'b0, 256, 50, -1, 1'b1);
        drain("drain_average_gaps");

        // mode pin toggled mid-frame, then the new mode takes effect
        run_frame(1'b0, 1'b0, 256, 0, 100, 1'b0);
        run_frame(1'b1, 1'b0, 256, 0, -1, 1'b0);
        drain("drain_mode_toggle");

        // frame restart at pixel 70, then at the last pixel of a frame
        run_frame(1'b1, 1'b0, 70, 0, -1, 1'b0);
        run_frame(1'b1, 1'b1, 256, 0, -1, 1'b0);
        drain("drain_restart_70");
        run_frame(1'b1, 1'b0, 255, 0, -1, 1'b0);
        run_frame(1'b0, 1'b1, 256, 0, -1, 1'b0);
        drain("drain_restart_last");

        // reset mid-frame while an output pulse is live
        run_frame(1'b0, 1'b0, 201, 0, -1, 1'b0);
        @(posedge clk);
        #2;
        check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_valid", 64'(bus.out_valid), 64'd0);
        check("async_reset_data",  64'(bus.out_data),  64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(1'b0, 1'b0, 256, 0, -1, 1'b0);
        drain("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
